xsleena_sdr_gfx_arbiter: RTL and testbench

- Shares one read-only SDRAM client port between the three graphics-ROM fetchers: OBJ, BACK1 and BACK2.
- Arbitrates requests round-robin and latches the granted address.
- Holds the SDRAM request until the SDRAM acknowledges, then returns the 16-bit word and a one-cycle ready pulse to the owning fetcher.
- A watchdog aborts hung transactions so a fetcher can never stall a scanline forever.

---
 rtl/xsleena_sdr_gfx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_xsleena_sdr_gfx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsleena_sdr_gfx_arbiter.sv
// Round-robin arbiter sharing one read-only SDRAM client port between the
// OBJ, BACK1 and BACK2 graphics-ROM fetchers, with a watchdog on hung reads.
module xsleena_sdr_gfx_arbiter #(
    parameter int AW      = 25,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [AW-1:0] obj_addr,
    input  logic          obj_req,
    output logic          obj_rdy,
    output logic [DW-1:0] obj_dout,
    input  logic [AW-1:0] bg1_addr,
    input  logic          bg1_req,
    output logic          bg1_rdy,
    output logic [DW-1:0] bg1_dout,
    input  logic [AW-1:0] bg2_addr,
    input  logic          bg2_req,
    output logic          bg2_rdy,
    output logic [DW-1:0] bg2_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          timeout_err
);

    localparam int CW = 10;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [1:0] OWN_OBJ = 2'd0;
    localparam logic [1:0] OWN_BG1 = 2'd1;
    localparam logic [1:0] OWN_BG2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      owner_reg;
    logic [1:0]      last_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic            mem_req_reg;
    logic [CW-1:0]   cnt_reg;
    logic            timeout_err_reg;
    logic [DW-1:0]   dout_reg [3];
    logic [2:0]      rdy_vec;

    logic [2:0]      req_vec;
    logic [AW-1:0]   addr_arr [3];
    logic [1:0]      pick_idx;
    logic            grant_en;
    logic            capture_en;
    logic            abort_en;

    assign req_vec     = {bg2_req, bg1_req, obj_req};
    assign addr_arr[0] = obj_addr;
    assign addr_arr[1] = bg1_addr;
    assign addr_arr[2] = bg2_addr;

    // First requester after the last-served one, cyclic OBJ -> BG1 -> BG2.
    always_comb begin
        pick_idx = last_reg;
        unique case (last_reg)
            OWN_OBJ: pick_idx = req_vec[1] ? OWN_BG1 : (req_vec[2] ? OWN_BG2 : OWN_OBJ);
            OWN_BG1: pick_idx = req_vec[2] ? OWN_BG2 : (req_vec[0] ? OWN_OBJ : OWN_BG1);
            default: pick_idx = req_vec[0] ? OWN_OBJ : (req_vec[1] ? OWN_BG1 : OWN_BG2);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        abort_en   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_en   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_rdy) begin
                    capture_en = 1'b1;
                    state_next = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                    abort_en   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            owner_reg       <= OWN_OBJ;
            last_reg        <= OWN_BG2;
            mem_addr_reg    <= '0;
            mem_req_reg     <= 1'b0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (grant_en) begin
                mem_addr_reg <= addr_arr[pick_idx];
                owner_reg    <= pick_idx;
                last_reg     <= pick_idx;
            end
            if (state_reg == ST_ISSUE) begin
                mem_req_reg <= 1'b1;
            end else if (capture_en || abort_en) begin
                mem_req_reg <= 1'b0;
            end
            if (state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (state_reg == ST_DONE) begin
                cnt_reg <= '0;
            end
            if (abort_en) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    // Per-client return word and ready strobe; aborted reads return all ones.
    for (genvar gi = 0; gi < 3; gi++) begin : g_client
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                dout_reg[gi] <= '0;
            end else if (owner_reg == 2'(gi)) begin
                if (capture_en) begin
                    dout_reg[gi] <= mem_dout;
                end else if (abort_en) begin
                    dout_reg[gi] <= '1;
                end
            end
        end
        assign rdy_vec[gi] = (state_reg == ST_DONE) && (owner_reg == 2'(gi));
    end

    assign obj_rdy     = rdy_vec[0];
    assign bg1_rdy     = rdy_vec[1];
    assign bg2_rdy     = rdy_vec[2];
    assign obj_dout    = dout_reg[0];
    assign bg1_dout    = dout_reg[1];
    assign bg2_dout    = dout_reg[2];
    assign mem_addr    = mem_addr_reg;
    assign mem_req     = mem_req_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_xsleena_sdr_gfx_arbiter.sv
// Directed bench for the graphics SDRAM arbiter: single reads, rotation,
// address latching, watchdog abort, async reset and minimum latency.
module tb_xsleena_sdr_gfx_arbiter;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [24:0] obj_addr, bg1_addr, bg2_addr;
    logic        obj_req, bg1_req, bg2_req;
    logic        obj_rdy, bg1_rdy, bg2_rdy;
    logic [15:0] obj_dout, bg1_dout, bg2_dout;
    logic [24:0] mem_addr;
    logic        mem_req;
    logic        mem_rdy = 1'b0;
    logic [15:0] mem_dout = 16'h0000;
    logic        busy, timeout_err;

    int checks   = 0;
    int failures = 0;
    int rdy_cnt [3];

    // SDRAM model controls
    int          ack_delay = 3;
    bit          ack_off   = 1'b0;
    bit          stray     = 1'b0;
    logic [15:0] ack_data  = 16'h0000;
    int          wcnt      = 0;

    always #5 CLK = ~CLK;

    xsleena_sdr_gfx_arbiter #(.AW(25), .DW(16), .TIMEOUT(8)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .obj_addr   (obj_addr),
        .obj_req    (obj_req),
        .obj_rdy    (obj_rdy),
        .obj_dout   (obj_dout),
        .bg1_addr   (bg1_addr),
        .bg1_req    (bg1_req),
        .bg1_rdy    (bg1_rdy),
        .bg1_dout   (bg1_dout),
        .bg2_addr   (bg2_addr),
        .bg2_req    (bg2_req),
        .bg2_rdy    (bg2_rdy),
        .bg2_dout   (bg2_dout),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_rdy    (mem_rdy),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // SDRAM: acks ack_delay cycles after mem_req is first seen high.
    always @(negedge CLK) begin
        mem_rdy = 1'b0;
        if (stray) begin
            mem_rdy = 1'b1;
            stray   = 1'b0;
        end else if (mem_req) begin
            if (!ack_off && wcnt == ack_delay) begin
                mem_rdy  = 1'b1;
                mem_dout = ack_data;
            end
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input int bound, output int who, output logic [15:0] d,
                            output logic [24:0] a, output int cyc, output int wcyc,
                            output bit stable);
        bit found;
        found  = 1'b0;
        who    = 3;
        d      = '0;
        a      = '0;
        cyc    = 0;
        wcyc   = 0;
        stable = 1'b1;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge CLK);
            cyc++;
            if (mem_req) begin
                if (wcyc == 0) a = mem_addr;
                else if (mem_addr !== a) stable = 1'b0;
                wcyc++;
            end
            if (obj_rdy || bg1_rdy || bg2_rdy) begin
                found = 1'b1;
                check("rdy_onehot", 32'($countones({obj_rdy, bg1_rdy, bg2_rdy})), 32'd1);
                who = obj_rdy ? 0 : (bg1_rdy ? 1 : 2);
                d   = obj_rdy ? obj_dout : (bg1_rdy ? bg1_dout : bg2_dout);
                rdy_cnt[who]++;
            end
        end
        check("rdy_seen", 32'(found), 32'd1);
        $display("TXN owner=%0d dout=0x%04h addr=0x%07h cycles=%0d wait=%0d", who, d, a, cyc, wcyc);
    endtask

    task automatic wait_mem_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = mem_req;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
        @(negedge CLK);
    endtask

    int          who, cyc, wcyc;
    logic [15:0] d;
    logic [24:0] a;
    bit          stable;
    bit          any_rdy;
    logic [24:0] rot_addr [3];

    initial begin
        RSTn = 1'b0;
        obj_req = 1'b0; bg1_req = 1'b0; bg2_req = 1'b0;
        obj_addr = '0; bg1_addr = '0; bg2_addr = '0;
        for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;

        // Reset state
        #12;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memaddr", 32'(mem_addr), 32'd0);
        check("rst_rdy",    32'({obj_rdy, bg1_rdy, bg2_rdy}), 32'd0);
        check("rst_dout",   32'(obj_dout | bg1_dout | bg2_dout), 32'd0);
        check("rst_toerr",  32'(timeout_err), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // Single OBJ read, ack 3 cycles after mem_req
        ack_delay = 3; ack_data = 16'hBEEF;
        obj_addr = 25'h0123456; obj_req = 1'b1;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        obj_req = 1'b0;
        check("t1_owner", 32'(who), 32'd0);
        check("t1_dout",  32'(d), 32'hBEEF);
        check("t1_addr",  32'(a), 32'h0123456);
        check("t1_wait",  32'(wcyc), 32'd4);
        check("t1_other_dout", 32'(bg1_dout | bg2_dout), 32'd0);
        @(negedge CLK);
        check("t1_rdy_single", 32'({obj_rdy, bg1_rdy, bg2_rdy}), 32'd0);
        check("t1_busy_idle",  32'(busy), 32'd0);

        // All three requesting: strict rotation from OBJ after reset
        do_reset();
        rot_addr[0] = 25'h10; rot_addr[1] = 25'h20; rot_addr[2] = 25'h30;
        obj_addr = rot_addr[0]; bg1_addr = rot_addr[1]; bg2_addr = rot_addr[2];
        ack_delay = 1;
        ack_data = 16'h1000;
        obj_req = 1'b1; bg1_req = 1'b1; bg2_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ack_data = 16'h1000 + 16'(k);
            wait_rdy(40, who, d, a, cyc, wcyc, stable);
            check($sformatf("rot%0d_owner", k), 32'(who), 32'(k % 3));
            check($sformatf("rot%0d_dout", k), 32'(d), 32'h1000 + 32'(k));
            check($sformatf("rot%0d_addr", k), 32'(a), 32'(rot_addr[k % 3]));
        end
        obj_req = 1'b0; bg1_req = 1'b0; bg2_req = 1'b0;
        @(negedge CLK);
        check("rot_cnt_obj", 32'(rdy_cnt[0]), 32'd3);
        check("rot_cnt_bg1", 32'(rdy_cnt[1]), 32'd3);
        check("rot_cnt_bg2", 32'(rdy_cnt[2]), 32'd3);

        // Address changes after grant are ignored
        ack_delay = 3; ack_data = 16'h4444;
        bg1_addr = 25'h40; bg1_req = 1'b1;
        wait_mem_req("t3_memreq_seen");
        bg1_addr = 25'h44;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        check("t3_owner",  32'(who), 32'd1);
        check("t3_addr",   32'(a), 32'h40);
        check("t3_stable", 32'(stable), 32'd1);
        check("t3_done_addr", 32'(mem_addr), 32'h40);
        ack_data = 16'h4545;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        bg1_req = 1'b0;
        check("t3b_addr", 32'(a), 32'h44);
        check("t3b_dout", 32'(d), 32'h4545);
        @(negedge CLK);

        // Watchdog abort with TIMEOUT=8
        ack_off = 1'b1;
        bg2_addr = 25'h77; bg2_req = 1'b1;
        wait_rdy(60, who, d, a, cyc, wcyc, stable);
        bg2_req = 1'b0;
        check("t4_owner", 32'(who), 32'd2);
        check("t4_dout",  32'(d), 32'hFFFF);
        check("t4_wait",  32'(wcyc), 32'd8);
        check("t4_toerr", 32'(timeout_err), 32'd1);
        check("t4_obj_hold", 32'(obj_dout), 32'h1006);
        check("t4_bg1_hold", 32'(bg1_dout), 32'h4545);
        @(negedge CLK);
        @(negedge CLK);
        check("t4_toerr_sticky", 32'(timeout_err), 32'd1);
        ack_off = 1'b0;
        stray = 1'b1;
        any_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            any_rdy |= (obj_rdy | bg1_rdy | bg2_rdy | busy);
        end
        check("t4_stray_ignored", 32'(any_rdy), 32'd0);
        check("t4_toerr_after_stray", 32'(timeout_err), 32'd1);

        // Asynchronous reset in the middle of WAIT
        ack_delay = 5;
        obj_addr = 25'h1AB; obj_req = 1'b1;
        wait_mem_req("t5_memreq_seen");
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("t5_async_memreq", 32'(mem_req), 32'd0);
        check("t5_async_busy",   32'(busy), 32'd0);
        check("t5_async_toerr",  32'(timeout_err), 32'd0);
        obj_req = 1'b0;
        any_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            any_rdy |= (obj_rdy | bg1_rdy | bg2_rdy);
        end
        check("t5_no_rdy", 32'(any_rdy), 32'd0);
        ack_delay = 1; ack_data = 16'h5151;
        obj_addr = 25'h500; bg2_addr = 25'h502;
        obj_req = 1'b1; bg2_req = 1'b1;
        RSTn = 1'b1;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        obj_req = 1'b0;
        check("t5_first_owner", 32'(who), 32'd0);
        check("t5_first_addr",  32'(a), 32'h500);
        ack_data = 16'h5252;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        bg2_req = 1'b0;
        check("t5_second_owner", 32'(who), 32'd2);
        check("t5_second_dout",  32'(d), 32'h5252);
        @(negedge CLK);

        // Minimum latency: ack on the first mem_req cycle
        ack_delay = 0; ack_data = 16'h6060;
        @(negedge CLK);
        bg1_addr = 25'h99; bg1_req = 1'b1;
        wait_rdy(40, who, d, a, cyc, wcyc, stable);
        bg1_req = 1'b0;
        check("t6_owner",   32'(who), 32'd1);
        check("t6_latency", 32'(cyc), 32'd3);
        check("t6_wait",    32'(wcyc), 32'd1);
        check("t6_dout",    32'(d), 32'h6060);
        @(negedge CLK);
        check("t6_busy_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
